// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: word-organised RAM behind a request/response-pulse handshake.
// Optional macro DMEM_MISALIGN_TRAP_EN reports misaligned accesses instead of forcing alignment.
module dmem_lsu #(
  parameter int unsigned ADDR_W    = 10,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  MemReadSize,
  input  logic        MemReadSigned,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        misalign
);

  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam logic [31:0] INIT_WORD = (INIT_ZERO != 1'b0) ? '0 : 'x;

  typedef enum logic {IDLE, RESP} state_t;

  state_t state, state_next;

  logic [31:0] mem [DEPTH] = '{default: INIT_WORD};

  logic [ADDR_W-1:0] idx;
  logic [1:0]        off;
  logic [1:0]        off_eff;
  logic              accept;
  logic              is_store;
  logic              store_ok;
  logic              is_load;
  logic              half_acc;
  logic              word_acc;
  logic              trap;
  logic [3:0]        lanes;
  logic [31:0]       wdata_rep;
  logic              wr_en;
  logic              rd_en;
  logic              unused_addr_hi;

  logic              load_r;
  logic              trap_r;
  logic [1:0]        off_r;
  logic [1:0]        size_r;
  logic              sign_r;
  logic [31:0]       word_r;

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       ext;

  assign idx            = addr[ADDR_W+1:2];
  assign off            = addr[1:0];
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  assign is_store = |MemWrite;
  assign store_ok = (MemWrite == 4'b0001) || (MemWrite == 4'b0011) || (MemWrite == 4'b1111);
  assign is_load  = !is_store && MemRead;
  assign half_acc = is_store ? (MemWrite == 4'b0011) : (MemReadSize == 2'd1);
  assign word_acc = is_store ? (MemWrite == 4'b1111) : MemReadSize[1];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap    = (is_load || store_ok) && ((half_acc && off[0]) || (word_acc && (off != 2'd0)));
  assign off_eff = off;
`else
  assign trap    = 1'b0;
  assign off_eff = word_acc ? 2'd0 : (half_acc ? {off[1], 1'b0} : off);
`endif

  assign lanes = MemWrite << off_eff;

  always_comb begin
    case (MemWrite)
      4'b0001: wdata_rep = {4{wdata[7:0]}};
      4'b0011: wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  // rst blocks the accept, so a request seen during reset never touches the RAM.
  assign wr_en = accept && !rst && store_ok && !trap;
  assign rd_en = accept && !rst && is_load && !trap;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lanes[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
    if (rd_en) word_r <= mem[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_r <= 1'b0;
      trap_r <= 1'b0;
      off_r  <= '0;
      size_r <= '0;
      sign_r <= 1'b0;
    end else if (accept) begin
      load_r <= is_load;
      trap_r <= trap;
      off_r  <= off_eff;
      size_r <= MemReadSize;
      sign_r <= MemReadSigned;
    end
  end

  always_comb begin
    case (off_r)
      2'd0:    byte_sel = word_r[7:0];
      2'd1:    byte_sel = word_r[15:8];
      2'd2:    byte_sel = word_r[23:16];
      default: byte_sel = word_r[31:24];
    endcase
    half_sel = off_r[1] ? word_r[31:16] : word_r[15:0];
    case (size_r)
      2'd0:    ext = {{24{sign_r & byte_sel[7]}}, byte_sel};
      2'd1:    ext = {{16{sign_r & half_sel[15]}}, half_sel};
      default: ext = word_r;
    endcase
  end

  // A reset landing on the response cycle swallows the pulse and its qualifiers.
  assign rsp_valid = (state == RESP) && !rst;
  assign rdata     = (rsp_valid && load_r && !trap_r) ? ext : '0;
  assign misalign  = rsp_valid && trap_r;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed cases plus randomized requests against a byte-addressed memory model.
// Honours DMEM_MISALIGN_TRAP_EN so the same bench covers both builds.
module tb_dmem_lsu;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned NBYTES = 4 * (2 ** ADDR_W);
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  MemWrite;
  logic        MemRead;
  logic [1:0]  MemReadSize;
  logic        MemReadSigned;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        misalign;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mref [NBYTES];

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(ADDR_W), .INIT_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .addr(addr), .wdata(wdata), .MemWrite(MemWrite), .MemRead(MemRead),
    .MemReadSize(MemReadSize), .MemReadSigned(MemReadSigned),
    .rsp_valid(rsp_valid), .rdata(rdata), .misalign(misalign)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-level reference: an access touches n consecutive bytes starting at the (aligned) address.
  task automatic model_req(input logic [3:0] mw, input logic mr, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a_in, input logic [31:0] wd,
                           output logic [31:0] exp_rd, output logic exp_mis);
    int unsigned a, n;
    logic [31:0] v;
    a = a_in % NBYTES;
    exp_rd = '0;
    exp_mis = 1'b0;
    if (mw != 4'd0) begin
      n = (mw == 4'b0001) ? 1 : (mw == 4'b0011) ? 2 : (mw == 4'b1111) ? 4 : 0;
      if (n == 0) return;
      if (a % n != 0) begin
        if (TRAP) begin exp_mis = 1'b1; return; end
        a = a - a % n;
      end
      for (int k = 0; k < int'(n); k++) mref[a + k] = wd[8*k +: 8];
    end else if (mr) begin
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      if (a % n != 0) begin
        if (TRAP) begin exp_mis = 1'b1; return; end
        a = a - a % n;
      end
      v = '0;
      for (int k = 0; k < int'(n); k++) v[8*k +: 8] = mref[a + k];
      if (n == 1 && sg && v[7])  v[31:8]  = '1;
      if (n == 2 && sg && v[15]) v[31:16] = '1;
      exp_rd = v;
    end
  endtask

  task automatic drive(input logic [3:0] mw, input logic mr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd);
    MemWrite = mw; MemRead = mr; MemReadSize = sz; MemReadSigned = sg; addr = a; wdata = wd;
  endtask

  task automatic scramble();
    drive(4'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
  endtask

  // Starts and ends at a falling edge with the DUT idle.
  task automatic do_req(input string tag, input logic [3:0] mw, input logic mr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] got);
    logic [31:0] er;
    logic em;
    check({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    drive(mw, mr, sz, sg, a, wd);
    req_valid = 1'b1;
    model_req(mw, mr, sz, sg, a, wd, er, em);
    @(posedge clk);
    #1;
    scramble();
    req_valid = 1'($urandom);
    @(negedge clk);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_rdata"}, rdata, er);
    check({tag, "_misalign"}, 32'(misalign), 32'(em));
    check({tag, "_ready_resp"}, 32'(req_ready), 32'd0);
    got = rdata;
    req_valid = 1'b0;
    @(negedge clk);
    check({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic rst_in_resp(input string tag, input logic [3:0] mw, input logic mr, input logic [31:0] a,
                             input logic [31:0] wd);
    logic [31:0] er;
    logic em;
    drive(mw, mr, 2'd2, 1'b0, a, wd);
    req_valid = 1'b1;
    model_req(mw, mr, 2'd2, 1'b0, a, wd, er, em);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check({tag, "_rsp_suppressed"}, 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_after"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    int pulses;
    logic [3:0] mw;
    logic [31:0] a;

    for (int i = 0; i < int'(NBYTES); i++) mref[i] = 8'h00;
    rst = 1'b1;
    req_valid = 1'b0;
    drive(4'd0, 1'b0, 2'd0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_rsp", 32'(rsp_valid), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_misalign", 32'(misalign), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_req("sw10", 4'b1111, 1'b0, 2'd0, 1'b0, 32'h10, 32'hDEADBEEF, got);
    do_req("lw10", 4'b0000, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, got);
    check("lw10_const", got, 32'hDEADBEEF);

    do_req("sw10b", 4'b1111, 1'b0, 2'd0, 1'b0, 32'h10, 32'h11223344, got);
    do_req("sb13", 4'b0001, 1'b1, 2'd2, 1'b0, 32'h13, 32'h000000AA, got);
    check("sb13_rdata_const", got, 32'h0);
    do_req("lw10c", 4'b0000, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, got);
    check("lw10c_const", got, 32'hAA223344);
    do_req("lb13", 4'b0000, 1'b1, 2'd0, 1'b1, 32'h13, 32'h0, got);
    check("lb13_const", got, 32'hFFFFFFAA);
    do_req("lbu13", 4'b0000, 1'b1, 2'd0, 1'b0, 32'h13, 32'h0, got);
    check("lbu13_const", got, 32'h000000AA);

    do_req("sw20", 4'b1111, 1'b0, 2'd0, 1'b0, 32'h20, 32'h11117777, got);
    do_req("sh22", 4'b0011, 1'b0, 2'd0, 1'b0, 32'h22, 32'h00008001, got);
    do_req("lh22", 4'b0000, 1'b1, 2'd1, 1'b1, 32'h22, 32'h0, got);
    check("lh22_const", got, 32'hFFFF8001);
    do_req("lhu22", 4'b0000, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0, got);
    check("lhu22_const", got, 32'h00008001);
    do_req("lw20", 4'b0000, 1'b1, 2'd3, 1'b1, 32'h20, 32'h0, got);
    check("lw20_const", got, 32'h80017777);

    do_req("sw20b", 4'b1111, 1'b0, 2'd0, 1'b0, 32'h20, 32'hCAFEF00D, got);
    do_req("lh21", 4'b0000, 1'b1, 2'd1, 1'b1, 32'h21, 32'h0, got);
    check("lh21_const", got, TRAP ? 32'h0 : 32'hFFFFF00D);
    do_req("sw22", 4'b1111, 1'b0, 2'd0, 1'b0, 32'h22, 32'h12345678, got);
    do_req("lw20m", 4'b0000, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, got);
    check("lw20m_const", got, TRAP ? 32'hCAFEF00D : 32'h12345678);

    do_req("sw1010", 4'b1111, 1'b0, 2'd0, 1'b0, 32'h1010, 32'h0BADF00D, got);
    do_req("lw010", 4'b0000, 1'b1, 2'd2, 1'b0, 32'h010, 32'h0, got);
    check("alias_const", got, 32'h0BADF00D);
    do_req("bad_mask", 4'b0101, 1'b1, 2'd2, 1'b0, 32'h10, 32'hFFFFFFFF, got);
    do_req("lw010b", 4'b0000, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, got);
    check("bad_mask_const", got, 32'h0BADF00D);
    do_req("noop", 4'b0000, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got);

    // req_valid held high across three no-op requests.
    drive(4'd0, 1'b0, 2'd0, 1'b0, 32'h40, 32'h0);
    req_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      check("b2b_ready", 32'(req_ready), 32'((i % 2) == 0));
      check("b2b_rsp", 32'(rsp_valid), 32'((i % 2) == 1));
      if (rsp_valid) pulses++;
      if (i == 5) req_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b_pulses", 32'(pulses), 32'd3);

    rst_in_resp("rst_load", 4'b0000, 1'b1, 32'h10, 32'h0);
    rst_in_resp("rst_store", 4'b1111, 1'b0, 32'h34, 32'h5A5AA5A5);
    do_req("rst_store_rd", 4'b0000, 1'b1, 2'd2, 1'b0, 32'h34, 32'h0, got);
    check("rst_store_const", got, 32'h5A5AA5A5);

    rst = 1'b1;
    drive(4'b1111, 1'b0, 2'd0, 1'b0, 32'h30, 32'hFFFFFFFF);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_req_rsp", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    do_req("rst_req_rd", 4'b0000, 1'b1, 2'd2, 1'b0, 32'h30, 32'h0, got);
    check("rst_req_const", got, 32'h0);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0:       mw = 4'b0001;
        1:       mw = 4'b0011;
        2:       mw = 4'b1111;
        3:       mw = 4'($urandom);
        default: mw = 4'b0000;
      endcase
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      do_req("rand", mw, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, got);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
